// File: rtl/rpm_pkg.sv
// rtl/rpm_pkg.sv - shared types and constants for the tach blip generator
package rpm_pkg;

    typedef logic [15:0] rpm_t;
    typedef logic [31:0] clk_cnt_t;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        RUN
    } blip_state_e;

    // Clocks per minute divided by two: half-cycles of a 1 pole-change-per-minute wave.
    function automatic clk_cnt_t blip_numerator(input longint clk_hz);
        longint prod;
        prod = clk_hz * 64'sd30;
        return prod[31:0];
    endfunction

endpackage

// File: rtl/seq_divider_u32.sv
// rtl/seq_divider_u32.sv - 32-bit unsigned restoring divider, 32 iterations per result
module seq_divider_u32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quotient
);

    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] div_q;
    logic [4:0]  iter_q;
    logic        busy_q;
    logic [32:0] shifted;
    logic [32:0] diff;

    // The dividend shifts out of quo_q MSB-first while quotient bits shift in.
    assign shifted  = {rem_q, quo_q[31]};
    assign diff     = shifted - {1'b0, div_q};
    assign quotient = quo_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            div_q  <= '0;
            iter_q <= '0;
            busy_q <= 1'b0;
            done   <= 1'b0;
        end else if (abort) begin
            busy_q <= 1'b0;
            done   <= 1'b0;
        end else if (start) begin
            rem_q  <= '0;
            quo_q  <= dividend;
            div_q  <= divisor;
            iter_q <= '0;
            busy_q <= 1'b1;
            done   <= 1'b0;
        end else if (busy_q) begin
            if (!diff[32]) begin
                rem_q <= diff[31:0];
                quo_q <= {quo_q[30:0], 1'b1};
            end else begin
                rem_q <= shifted[31:0];
                quo_q <= {quo_q[30:0], 1'b0};
            end
            iter_q <= iter_q + 5'd1;
            if (iter_q == 5'd31) begin
                busy_q <= 1'b0;
                done   <= 1'b1;
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/rpm_blip_gen.sv
// rtl/rpm_blip_gen.sv - commanded RPM to 50%-duty tach blip train
module rpm_blip_gen
    import rpm_pkg::*;
#(
    parameter int CLK_HZ           = 50000000,
    parameter int MOTOR_POLE_COUNT = 16,
    parameter int GEAR_RATIO       = 5
) (
    input  logic        clk50M,
    input  logic        rst_n,
    input  rpm_t        rpm_set,
    input  logic        rpm_valid,
    output logic        ready,
    output logic        blips,
    output clk_cnt_t    half_period,
    output logic [15:0] blip_count
);

    localparam clk_cnt_t NUMERATOR = blip_numerator(longint'(CLK_HZ));
    localparam clk_cnt_t POLES_X_GEAR = clk_cnt_t'(MOTOR_POLE_COUNT * GEAR_RATIO);

    blip_state_e state_q, state_d;
    clk_cnt_t    denom;
    clk_cnt_t    div_quot;
    clk_cnt_t    quot_clamped;
    clk_cnt_t    phase_q;
    clk_cnt_t    pend_q;
    logic        pend_v_q;
    logic        running_q;
    logic        div_done_raw;
    logic        div_done;
    logic        cmd_stop;
    logic        cmd_start;
    logic        toggle;

    assign cmd_stop     = rpm_valid && (rpm_set == '0);
    assign cmd_start    = rpm_valid && (rpm_set != '0);
    assign denom        = clk_cnt_t'(rpm_set) * POLES_X_GEAR;
    // A strobe landing on the completion cycle supersedes the finished result.
    assign div_done     = div_done_raw && !rpm_valid;
    assign quot_clamped = (div_quot == '0) ? clk_cnt_t'(1) : div_quot;
    assign toggle       = running_q && (phase_q == half_period - clk_cnt_t'(1));

    seq_divider_u32 u_div (
        .clk      (clk50M),
        .rst_n    (rst_n),
        .start    (cmd_start),
        .abort    (cmd_stop),
        .dividend (NUMERATOR),
        .divisor  (denom),
        .done     (div_done_raw),
        .quotient (div_quot)
    );

    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (cmd_stop)
            state_d = IDLE;
        else if (cmd_start)
            state_d = DIVIDE;
        else if (state_q == DIVIDE && div_done)
            state_d = RUN;
    end

    always_comb begin
        ready = (state_q != DIVIDE);
    end

    // The generator keeps running through a re-division; new periods land only on a toggle.
    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            running_q   <= 1'b0;
            blips       <= 1'b0;
            half_period <= '0;
            phase_q     <= '0;
            pend_q      <= '0;
            pend_v_q    <= 1'b0;
            blip_count  <= '0;
        end else if (cmd_stop) begin
            running_q   <= 1'b0;
            blips       <= 1'b0;
            half_period <= '0;
            phase_q     <= '0;
            pend_v_q    <= 1'b0;
        end else begin
            if (div_done && !running_q) begin
                half_period <= quot_clamped;
                phase_q     <= '0;
                running_q   <= 1'b1;
                blips       <= 1'b0;
                pend_v_q    <= 1'b0;
            end else if (running_q) begin
                if (toggle) begin
                    blips   <= ~blips;
                    phase_q <= '0;
                    if (!blips)
                        blip_count <= blip_count + 16'd1;
                    if (div_done)
                        half_period <= quot_clamped;
                    else if (pend_v_q && !rpm_valid)
                        half_period <= pend_q;
                    pend_v_q <= 1'b0;
                end else begin
                    phase_q <= phase_q + clk_cnt_t'(1);
                    if (div_done) begin
                        pend_q   <= quot_clamped;
                        pend_v_q <= 1'b1;
                    end
                end
            end
            if (cmd_start)
                pend_v_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rpm_blip_gen.sv
// tb/tb_rpm_blip_gen.sv - scoreboard bench for rpm_blip_gen
module tb_rpm_blip_gen;

    logic        clk50M = 1'b0;
    logic        rst_n;
    logic [15:0] rpm_set;
    logic        rpm_valid;
    logic        ready;
    logic        blips;
    logic [31:0] half_period;
    logic [15:0] blip_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int strobe_edge = 0;

    typedef struct {
        int due;
        int hp;
    } rdy_exp_t;

    rdy_exp_t rdy_q[$];
    int       hp_q[$];
    int       gap_q[$];

    rpm_blip_gen dut (
        .clk50M      (clk50M),
        .rst_n       (rst_n),
        .rpm_set     (rpm_set),
        .rpm_valid   (rpm_valid),
        .ready       (ready),
        .blips       (blips),
        .half_period (half_period),
        .blip_count  (blip_count)
    );

    always #10 clk50M = ~clk50M;

    always @(posedge clk50M) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input longint act);
        total++;
        bad++;
        $display("FAIL %s: got %0d with nothing expected (cycle %0d)", name, act, cyc);
    endtask

    // Monitor: compares every ready rise, half_period change and blips edge to the queues.
    logic prev_ready = 1'b1;
    logic prev_blips = 1'b0;
    int   prev_hp    = 0;
    int   last_t     = 0;

    always @(negedge clk50M) begin
        if (ready && !prev_ready) begin
            if (rdy_q.size() == 0) begin
                fail_now("rdy_unexpected", half_period);
            end else begin
                rdy_exp_t e;
                e = rdy_q.pop_front();
                check("rdy_cycle", cyc, e.due);
                check("rdy_half_period", half_period, e.hp);
            end
        end
        if (int'(half_period) != prev_hp) begin
            if (hp_q.size() == 0) fail_now("hp_unexpected", half_period);
            else                  check("hp_change", half_period, hp_q.pop_front());
            if (prev_hp == 0) last_t = cyc;
        end
        if (blips != prev_blips) begin
            int gap;
            gap    = cyc - last_t;
            last_t = cyc;
            if (gap_q.size() != 0) check("half_cycle_len", gap, gap_q.pop_front());
        end
        prev_ready = ready;
        prev_blips = blips;
        prev_hp    = int'(half_period);
    end

    task automatic strobe(input int v);
        @(negedge clk50M);
        rpm_set     = 16'(v);
        rpm_valid   = 1'b1;
        strobe_edge = cyc + 1;
        @(negedge clk50M);
        rpm_valid   = 1'b0;
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        while (!ready && n < budget) begin
            @(negedge clk50M);
            #2;
            n++;
        end
        if (!ready) fail_now("ready_timeout", n);
    endtask

    task automatic wait_gaps(input int budget);
        int n = 0;
        while (gap_q.size() != 0 && n < budget) begin
            @(negedge clk50M);
            #2;
            n++;
        end
        if (gap_q.size() != 0) begin
            fail_now("gap_timeout", gap_q.size());
            gap_q.delete();
        end
    endtask

    task automatic wait_blips_high(input int budget);
        int n = 0;
        while (!blips && n < budget) begin
            @(negedge clk50M);
            #2;
            n++;
        end
        if (!blips) fail_now("blips_high_timeout", n);
    endtask

    initial begin
        rst_n     = 1'b0;
        rpm_set   = '0;
        rpm_valid = 1'b0;
        repeat (3) @(negedge clk50M);
        check("reset_blips", blips, 0);
        check("reset_ready", ready, 1);
        check("reset_half_period", half_period, 0);
        check("reset_blip_count", blip_count, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk50M);

        // 1000 rpm from idle, then 750 mid-way through the first half-cycle
        strobe(1000);
        check("ready_low_1000", ready, 0);
        rdy_q.push_back('{due: strobe_edge + 33, hp: 18750});
        hp_q.push_back(18750);
        gap_q.push_back(18750);
        gap_q.push_back(25000);
        wait_ready(100);
        repeat (1000) @(negedge clk50M);
        strobe(750);
        check("ready_low_750", ready, 0);
        rdy_q.push_back('{due: strobe_edge + 33, hp: 18750});
        hp_q.push_back(25000);
        wait_gaps(50000);
        check("count_after_750", blip_count, 1);

        hp_q.push_back(0);
        strobe(0);
        check("stop_blips", blips, 0);
        check("stop_half_period", half_period, 0);
        check("stop_count_held", blip_count, 1);
        check("stop_ready", ready, 1);

        // maximum command from idle
        strobe(65535);
        check("ready_low_65535", ready, 0);
        rdy_q.push_back('{due: strobe_edge + 33, hp: 286});
        hp_q.push_back(286);
        for (int i = 0; i < 6; i++) gap_q.push_back(286);
        wait_gaps(2000);
        check("count_after_65535", blip_count, 4);

        // async reset while blips is high
        wait_blips_high(400);
        hp_q.push_back(0);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_blips", blips, 0);
        check("async_rst_count", blip_count, 0);
        check("async_rst_half_period", half_period, 0);
        repeat (2) @(negedge clk50M);
        rst_n = 1'b1;
        repeat (50) @(negedge clk50M);
        check("post_rst_blips", blips, 0);
        check("post_rst_half_period", half_period, 0);
        check("post_rst_ready", ready, 1);

        // 1000 superseded by 2000 ten cycles later
        strobe(1000);
        repeat (8) @(negedge clk50M);
        strobe(2000);
        check("ready_low_2000", ready, 0);
        rdy_q.push_back('{due: strobe_edge + 33, hp: 9375});
        hp_q.push_back(9375);
        gap_q.push_back(9375);
        wait_gaps(12000);
        check("count_after_2000", blip_count, 1);
        check("blips_high_2000", blips, 1);

        hp_q.push_back(0);
        strobe(0);
        check("stop2_blips", blips, 0);
        check("stop2_half_period", half_period, 0);
        check("stop2_count_held", blip_count, 1);

        repeat (5) @(negedge clk50M);
        check("rdy_q_drained", rdy_q.size(), 0);
        check("hp_q_drained", hp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
